titan_wb_arbiter: RTL and testbench
===================================

// Module: titan_wb_arbiter
// PURPOSE
//  Two-master to one-slave Wishbone (classic) arbiter for the Titan core.
//  Merges the instruction fetch port (iwbm_*) and the data/LSU port (dwbm_*) onto a single memory bus (wbm_*).
//  Each cycle is handed to one master at a time; the grant is held until the cycle completes.
//  A watchdog counter ends hung cycles with a bus error.
// PARAMETERS
//  ROUND_ROBIN     0    0: fixed priority, data wins ties; 1: the master that did not win last wins ties
//  TIMEOUT_CYCLES  255  granted cycles without ack/err before a forced error; 0 disables the watchdog
//  TIMEOUT_W       8    watchdog counter width; must satisfy TIMEOUT_CYCLES < 2**TIMEOUT_W
// PORTS
//  clk_i        in   1   core clock
//  rst_i        in   1   synchronous, active-high reset
//  iwbs_addr_i  in   32  fetch address
//  iwbs_cyc_i   in   1   fetch cycle
//  iwbs_stb_i   in   1   fetch strobe
//  iwbs_dat_o   out  32  fetch read data
//  iwbs_ack_o   out  1   fetch ack
//  iwbs_err_o   out  1   fetch error
//  dwbs_addr_i  in   32  data address
//  dwbs_dat_i   in   32  store data
//  dwbs_we_i    in   1   data write enable
//  dwbs_sel_i   in   4   byte selects
//  dwbs_cyc_i   in   1   data cycle
//  dwbs_stb_i   in   1   data strobe
//  dwbs_dat_o   out  32  load data
//  dwbs_ack_o   out  1   data ack
//  dwbs_err_o   out  1   data error
//  wbm_addr_o   out  32  bus address
//  wbm_dat_o    out  32  bus write data
//  wbm_we_o     out  1   bus write enable
//  wbm_sel_o    out  4   bus byte selects
//  wbm_cyc_o    out  1   bus cycle
//  wbm_stb_o    out  1   bus strobe
//  wbm_dat_i    in   32  bus read data
//  wbm_ack_i    in   1   bus ack
//  wbm_err_i    in   1   bus error
//  grant_o      out  2   {data,inst} one-hot grant; 00 when idle
// BEHAVIOUR
//  - Reset: state=IDLE, grant_o=00, last-winner=inst, watchdog=0.
//    All wbm_* outputs, acks and errs read 0; wbm_sel_o=0.
//  - States:
//      IDLE  -> IGNT  when only the inst port requests (cyc&stb).
//      IDLE  -> DGNT  when only the data port requests.
//      IDLE, both requesting: ROUND_ROBIN=0 -> DGNT; ROUND_ROBIN=1 -> grant the master that did not win last.
//      IGNT/DGNT -> IDLE on wbm_ack_i, wbm_err_i, watchdog expiry, or the granted master dropping cyc.
//  - Latency: a request seen in IDLE at cycle N drives wbm_cyc_o/stb_o from cycle N+1.
//    After completion at cycle M, the bus is idle in M+1; the next grant starts at M+2.
//  - While granted, the grantee's addr/dat/we/sel/cyc/stb drive wbm_* combinationally.
//    For a fetch grant, wbm_we_o=0 and wbm_sel_o=4'hF.
//    wbm_dat_i is routed to both dat_o ports; ack/err go only to the grantee.
//  - Non-granted master: ack=0, err=0; its request stays pending, never dropped or reordered.
//  - Simultaneous ack and err: err is forwarded and ack is masked.
//  - Watchdog: cleared on entry to a grant; increments each granted cycle with no ack/err.
//    On the cycle count==TIMEOUT_CYCLES: pulse err to the grantee for 1 cycle and go IDLE.
//    If ack arrives on the same cycle, ack wins and no err is raised.
//  - Master abort (cyc dropped mid-grant): wbm_cyc_o falls the same cycle; IDLE next cycle.
//    A late slave ack is discarded.
//  - Last-winner updates only when a grant is issued.
//  - Reset mid-transfer: IDLE and wbm_cyc_o=0 on the next edge; no ack or err is forwarded.
// TESTING
//  1. Fetch only, addr 0x100, slave acks 2 cycles after cyc -> wbm_cyc_o from N+1; iwbs_ack_o 1 cycle.
//     iwbs_dat_o=slave data; grant_o=01.
//  2. Both request at N, ROUND_ROBIN=0 -> data store (sel=0x3) completes first.
//     Fetch granted at M+2; iwbs_ack_o never pulses during the data grant.
//  3. ROUND_ROBIN=1, both requesting continuously, 6 transfers -> grants alternate D,I,D,I,D,I.
//  4. TIMEOUT_CYCLES=4, slave never acks -> dwbs_err_o pulses on the 5th granted cycle; IDLE next cycle.
//  5. rst_i asserted during a data grant with ack due next cycle -> wbm_cyc_o=0 and dwbs_ack_o=0 after the edge.
//  6. Fetch drops cyc mid-grant, slave acks 1 cycle later -> ack discarded; a pending data request is granted.

Source files
------------

// File: rtl/titan_wb_arbiter.sv
// Two-master (fetch, data) to one-slave Wishbone classic arbiter for the Titan core.
// The grant is held until ack, err, watchdog expiry or master abort.
module titan_wb_arbiter #(
    parameter int ROUND_ROBIN    = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] iwbs_addr_i,
    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    output logic [31:0] iwbs_dat_o,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,

    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    input  logic        dwbs_we_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    output logic [31:0] dwbs_dat_o,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o,

    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam bit                   WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam bit                   RR_EN    = (ROUND_ROBIN != 0);

    state_t               state, state_nxt;
    logic                 last_data, last_data_nxt;  // 1: data port won the last grant
    logic [TIMEOUT_W-1:0] wd_cnt, wd_cnt_nxt;

    logic i_req, d_req, pick_data;
    logic g_cyc, fwd_ack, fwd_err, wd_hit, done;

    assign i_req = iwbs_cyc_i & iwbs_stb_i;
    assign d_req = dwbs_cyc_i & dwbs_stb_i;

    // Slave responses only count while the grantee still holds cyc, so a late
    // ack after a master abort never reaches either port.
    always_comb begin
        g_cyc = 1'b0;
        if (state == IGNT) g_cyc = iwbs_cyc_i;
        if (state == DGNT) g_cyc = dwbs_cyc_i;
    end

    assign wd_hit  = WD_EN && g_cyc && (wd_cnt == WD_LIMIT) && !wbm_ack_i && !wbm_err_i;
    assign fwd_err = g_cyc & (wbm_err_i | wd_hit);
    assign fwd_ack = g_cyc & wbm_ack_i & ~wbm_err_i;
    assign done    = fwd_ack | fwd_err | ~g_cyc;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        last_data_nxt = last_data;
        wd_cnt_nxt    = wd_cnt;
        pick_data     = d_req;
        if (i_req && d_req) pick_data = RR_EN ? !last_data : 1'b1;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nxt     = pick_data ? DGNT : IGNT;
                    last_data_nxt = pick_data;
                    wd_cnt_nxt    = '0;
                end
            end
            IGNT, DGNT: begin
                if (done)       state_nxt  = IDLE;
                else if (WD_EN) wd_cnt_nxt = wd_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            last_data <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            last_data <= last_data_nxt;
            wd_cnt    <= wd_cnt_nxt;
        end
    end

    assign iwbs_dat_o = wbm_dat_i;
    assign dwbs_dat_o = wbm_dat_i;
    assign grant_o    = {state == DGNT, state == IGNT};

    always_comb begin
        wbm_addr_o = '0;
        wbm_dat_o  = '0;
        wbm_we_o   = 1'b0;
        wbm_sel_o  = '0;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        iwbs_ack_o = 1'b0;
        iwbs_err_o = 1'b0;
        dwbs_ack_o = 1'b0;
        dwbs_err_o = 1'b0;
        case (state)
            IGNT: begin
                wbm_addr_o = iwbs_addr_i;
                wbm_sel_o  = 4'hF;
                wbm_cyc_o  = iwbs_cyc_i;
                wbm_stb_o  = iwbs_stb_i;
                iwbs_ack_o = fwd_ack;
                iwbs_err_o = fwd_err;
            end
            DGNT: begin
                wbm_addr_o = dwbs_addr_i;
                wbm_dat_o  = dwbs_dat_i;
                wbm_we_o   = dwbs_we_i;
                wbm_sel_o  = dwbs_sel_i;
                wbm_cyc_o  = dwbs_cyc_i;
                wbm_stb_o  = dwbs_stb_i;
                dwbs_ack_o = fwd_ack;
                dwbs_err_o = fwd_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_titan_wb_arbiter.sv
// Directed bench for titan_wb_arbiter: instance 0 is fixed priority with a 4-cycle
// watchdog, instance 1 is round robin; completions are checked against a queue.
module tb_titan_wb_arbiter;

    logic clk;
    logic rst;

    logic [31:0] i_addr [2];
    logic        i_cyc  [2];
    logic        i_stb  [2];
    logic [31:0] i_dat  [2];
    logic        i_ack  [2];
    logic        i_err  [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdat [2];
    logic        d_we   [2];
    logic [3:0]  d_sel  [2];
    logic        d_cyc  [2];
    logic        d_stb  [2];
    logic [31:0] d_dat  [2];
    logic        d_ack  [2];
    logic        d_err  [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdat [2];
    logic        m_we   [2];
    logic [3:0]  m_sel  [2];
    logic        m_cyc  [2];
    logic        m_stb  [2];
    logic [31:0] m_rdat [2];
    logic        m_ack  [2];
    logic        m_err  [2];
    logic [1:0]  gnt    [2];

    titan_wb_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .iwbs_addr_i(i_addr[0]), .iwbs_cyc_i(i_cyc[0]), .iwbs_stb_i(i_stb[0]),
        .iwbs_dat_o(i_dat[0]), .iwbs_ack_o(i_ack[0]), .iwbs_err_o(i_err[0]),
        .dwbs_addr_i(d_addr[0]), .dwbs_dat_i(d_wdat[0]), .dwbs_we_i(d_we[0]),
        .dwbs_sel_i(d_sel[0]), .dwbs_cyc_i(d_cyc[0]), .dwbs_stb_i(d_stb[0]),
        .dwbs_dat_o(d_dat[0]), .dwbs_ack_o(d_ack[0]), .dwbs_err_o(d_err[0]),
        .wbm_addr_o(m_addr[0]), .wbm_dat_o(m_wdat[0]), .wbm_we_o(m_we[0]),
        .wbm_sel_o(m_sel[0]), .wbm_cyc_o(m_cyc[0]), .wbm_stb_o(m_stb[0]),
        .wbm_dat_i(m_rdat[0]), .wbm_ack_i(m_ack[0]), .wbm_err_i(m_err[0]),
        .grant_o(gnt[0])
    );

    titan_wb_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(255), .TIMEOUT_W(8)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .iwbs_addr_i(i_addr[1]), .iwbs_cyc_i(i_cyc[1]), .iwbs_stb_i(i_stb[1]),
        .iwbs_dat_o(i_dat[1]), .iwbs_ack_o(i_ack[1]), .iwbs_err_o(i_err[1]),
        .dwbs_addr_i(d_addr[1]), .dwbs_dat_i(d_wdat[1]), .dwbs_we_i(d_we[1]),
        .dwbs_sel_i(d_sel[1]), .dwbs_cyc_i(d_cyc[1]), .dwbs_stb_i(d_stb[1]),
        .dwbs_dat_o(d_dat[1]), .dwbs_ack_o(d_ack[1]), .dwbs_err_o(d_err[1]),
        .wbm_addr_o(m_addr[1]), .wbm_dat_o(m_wdat[1]), .wbm_we_o(m_we[1]),
        .wbm_sel_o(m_sel[1]), .wbm_cyc_o(m_cyc[1]), .wbm_stb_o(m_stb[1]),
        .wbm_dat_i(m_rdat[1]), .wbm_ack_i(m_ack[1]), .wbm_err_i(m_err[1]),
        .grant_o(gnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [1:0]  gnt;   // expected grantee at completion
        logic [31:0] dat;   // data the slave returns
        logic        err;   // completion is an error
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [1:0] g, input logic [31:0] d, input logic e);
        exp_t x;
        x.tag = tag;
        x.gnt = g;
        x.dat = d;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slave waits, then answers the oldest queued transfer; the completion is
    // compared against the queue and the bus must be idle the following cycle.
    task automatic respond(input int k, input int waits, input bit drop);
        exp_t e;
        for (int w = 0; w < waits; w++) begin
            step();
            @(negedge clk);
            check("no_early_done", {i_ack[k], i_err[k], d_ack[k], d_err[k]}, 4'b0000);
        end
        check("sb_depth", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            step();
            m_rdat[k] = e.dat;
            m_ack[k]  = !e.err;
            m_err[k]  = e.err;
            @(negedge clk);
            check({e.tag, "_grant"}, gnt[k], e.gnt);
            check({e.tag, "_iack"}, i_ack[k], e.gnt[0] & !e.err);
            check({e.tag, "_ierr"}, i_err[k], e.gnt[0] & e.err);
            check({e.tag, "_dack"}, d_ack[k], e.gnt[1] & !e.err);
            check({e.tag, "_derr"}, d_err[k], e.gnt[1] & e.err);
            if (e.gnt[0]) check({e.tag, "_idat"}, i_dat[k], e.dat);
            else          check({e.tag, "_ddat"}, d_dat[k], e.dat);
            step();
            m_ack[k] = 1'b0;
            m_err[k] = 1'b0;
            if (drop) begin
                if (e.gnt[0]) begin i_cyc[k] = 1'b0; i_stb[k] = 1'b0; end
                else          begin d_cyc[k] = 1'b0; d_stb[k] = 1'b0; end
            end
            @(negedge clk);
            check({e.tag, "_idle_gnt"}, gnt[k], 2'b00);
            check({e.tag, "_idle_cyc"}, m_cyc[k], 1'b0);
        end
    endtask

    initial begin
        int c;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            i_addr[k] = '0; i_cyc[k] = 1'b0; i_stb[k] = 1'b0;
            d_addr[k] = '0; d_wdat[k] = '0; d_we[k] = 1'b0; d_sel[k] = '0;
            d_cyc[k] = 1'b0; d_stb[k] = 1'b0;
            m_rdat[k] = '0; m_ack[k] = 1'b0; m_err[k] = 1'b0;
        end
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_gnt", gnt[k], 2'b00);
            check("rst_cyc_stb", {m_cyc[k], m_stb[k], m_we[k]}, 3'b000);
            check("rst_sel", m_sel[k], 4'h0);
            check("rst_addr", m_addr[k], 32'h0);
            check("rst_resp", {i_ack[k], i_err[k], d_ack[k], d_err[k]}, 4'b0000);
        end

        // Fetch only; slave acks two cycles after cyc rises.
        step();
        i_addr[0] = 32'h100; i_cyc[0] = 1'b1; i_stb[0] = 1'b1;
        push_exp("t1", 2'b01, 32'hCAFE_0001, 1'b0);
        @(negedge clk);
        check("t1_cyc_n", m_cyc[0], 1'b0);
        step();
        @(negedge clk);
        check("t1_cyc_n1", {m_cyc[0], m_stb[0], m_we[0]}, 3'b110);
        check("t1_addr", m_addr[0], 32'h100);
        check("t1_sel", m_sel[0], 4'hF);
        check("t1_gnt", gnt[0], 2'b01);
        respond(0, 1, 1'b1);

        // Both request together with fixed priority: data store first, then fetch.
        step();
        i_addr[0] = 32'h104; i_cyc[0] = 1'b1; i_stb[0] = 1'b1;
        d_addr[0] = 32'h200; d_wdat[0] = 32'h1122_3344; d_we[0] = 1'b1; d_sel[0] = 4'h3;
        d_cyc[0] = 1'b1; d_stb[0] = 1'b1;
        push_exp("t2_d", 2'b10, 32'hA5A5_0000, 1'b0);
        push_exp("t2_i", 2'b01, 32'hCAFE_0002, 1'b0);
        @(negedge clk);
        check("t2_gnt_n", gnt[0], 2'b00);
        step();
        @(negedge clk);
        check("t2_gnt_d", gnt[0], 2'b10);
        check("t2_we_sel", {m_we[0], m_sel[0]}, 5'b1_0011);
        check("t2_addr", m_addr[0], 32'h200);
        check("t2_wdat", m_wdat[0], 32'h1122_3344);
        respond(0, 0, 1'b1);
        step();
        @(negedge clk);
        check("t2_gnt_i", gnt[0], 2'b01);
        check("t2_addr_i", m_addr[0], 32'h104);
        check("t2_we_sel_i", {m_we[0], m_sel[0]}, 5'b0_1111);
        respond(0, 0, 1'b1);

        // Watchdog: no ack, error on the fifth granted cycle.
        step();
        d_addr[0] = 32'h300; d_we[0] = 1'b0; d_sel[0] = 4'hF; d_cyc[0] = 1'b1; d_stb[0] = 1'b1;
        push_exp("t4", 2'b10, 32'h0, 1'b1);
        @(negedge clk);
        c = 0;
        do begin
            step();
            @(negedge clk);
            c++;
        end while (!(d_err[0] | d_ack[0]) && c < 20);
        check("t4_err_cycle", c, 5);
        void'(exp_q.pop_front());
        check("t4_resp", {d_ack[0], d_err[0], i_ack[0], i_err[0]}, 4'b0100);
        check("t4_gnt", gnt[0], 2'b10);
        step();
        d_cyc[0] = 1'b0; d_stb[0] = 1'b0;
        @(negedge clk);
        check("t4_pulse", d_err[0], 1'b0);
        check("t4_idle", gnt[0], 2'b00);

        // Ack on the watchdog expiry cycle wins over the timeout.
        step();
        d_addr[0] = 32'h304; d_cyc[0] = 1'b1; d_stb[0] = 1'b1;
        push_exp("t4b", 2'b10, 32'h55AA_55AA, 1'b0);
        @(negedge clk);
        respond(0, 4, 1'b1);

        // Synchronous reset during a data grant with an ack due next cycle.
        step();
        d_addr[0] = 32'h400; d_cyc[0] = 1'b1; d_stb[0] = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t5_gnt", gnt[0], 2'b10);
        step();
        rst = 1'b0;
        m_ack[0] = 1'b1;
        @(negedge clk);
        check("t5_cyc", m_cyc[0], 1'b0);
        check("t5_ack", d_ack[0], 1'b0);
        check("t5_gnt_idle", gnt[0], 2'b00);
        step();
        m_ack[0] = 1'b0;
        d_cyc[0] = 1'b0; d_stb[0] = 1'b0;
        step();
        @(negedge clk);
        check("t5_settle", gnt[0], 2'b00);

        // Fetch aborts mid-grant; late slave ack is dropped and pending data is served.
        step();
        i_addr[0] = 32'h500; i_cyc[0] = 1'b1; i_stb[0] = 1'b1;
        @(negedge clk);
        step();
        d_addr[0] = 32'h600; d_wdat[0] = 32'hDEAD_BEEF; d_we[0] = 1'b1; d_sel[0] = 4'hF;
        d_cyc[0] = 1'b1; d_stb[0] = 1'b1;
        push_exp("t6", 2'b10, 32'h0BAD_F00D, 1'b0);
        @(negedge clk);
        check("t6_gnt_i", gnt[0], 2'b01);
        step();
        i_cyc[0] = 1'b0; i_stb[0] = 1'b0;
        @(negedge clk);
        check("t6_abort_cyc", m_cyc[0], 1'b0);
        check("t6_abort_gnt", gnt[0], 2'b01);
        step();
        m_ack[0] = 1'b1;
        @(negedge clk);
        check("t6_late_ack", {i_ack[0], d_ack[0]}, 2'b00);
        check("t6_idle", gnt[0], 2'b00);
        step();
        m_ack[0] = 1'b0;
        @(negedge clk);
        check("t6_gnt_d", gnt[0], 2'b10);
        check("t6_addr_d", m_addr[0], 32'h600);
        respond(0, 0, 1'b1);

        // Round robin with both masters requesting continuously.
        step();
        i_addr[1] = 32'h700; i_cyc[1] = 1'b1; i_stb[1] = 1'b1;
        d_addr[1] = 32'h800; d_sel[1] = 4'hF; d_cyc[1] = 1'b1; d_stb[1] = 1'b1;
        for (int j = 0; j < 6; j++)
            push_exp($sformatf("t3_%0d", j), (j % 2 == 0) ? 2'b10 : 2'b01, 32'h3000_0000 + 32'(j), 1'b0);
        @(negedge clk);
        for (int j = 0; j < 6; j++) respond(1, 0, 1'b0);
        step();
        i_cyc[1] = 1'b0; i_stb[1] = 1'b0; d_cyc[1] = 1'b0; d_stb[1] = 1'b0;
        step();
        @(negedge clk);
        check("t3_idle", gnt[1], 2'b00);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
